pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 43 ++++
 rtl/pipe_ctrl.sv | 103 ++++++++++
 tb/tb_pipe_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if -- hazard/stall bundle between the pipeline datapath and pipe_ctrl.
//   slave  : the controller (takes hazard inputs, drives enables/flushes/status)
//   master : the datapath side (drives hazard inputs, observes controls)
// Inputs : id_rs/id_rt (+valid), ex_w_reg, ex_reg_w_en, ex_read_mem,
//          ex_branch_taken, mem_busy, halt_req
// Outputs: pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
//          if_id_flush, id_ex_flush, halted, stall_cnt[15:0]
interface pipe_ctrl_if;
   logic [2:0]  id_rs;
   logic        id_rs_valid;
   logic [2:0]  id_rt;
   logic        id_rt_valid;
   logic [2:0]  ex_w_reg;
   logic        ex_reg_w_en;
   logic        ex_read_mem;
   logic        ex_branch_taken;
   logic        mem_busy;
   logic        halt_req;

   logic        pc_en;
   logic        if_id_en;
   logic        id_ex_en;
   logic        ex_mem_en;
   logic        mem_wb_en;
   logic        if_id_flush;
   logic        id_ex_flush;
   logic        halted;
   logic [15:0] stall_cnt;

   modport slave (
      input  id_rs, id_rs_valid, id_rt, id_rt_valid, ex_w_reg, ex_reg_w_en,
             ex_read_mem, ex_branch_taken, mem_busy, halt_req,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, halted, stall_cnt
   );

   modport master (
      output id_rs, id_rs_valid, id_rt, id_rt_valid, ex_w_reg, ex_reg_w_en,
             ex_read_mem, ex_branch_taken, mem_busy, halt_req,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, halted, stall_cnt
   );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- 5-stage pipeline hazard controller.
// Generates PC / pipeline-register write enables and bubble-insert flushes
// from load-use, taken-branch, memory-busy and halt conditions, and keeps a
// saturating count of stall cycles.
// Ports:
//   clk  : pipeline clock, rising edge
//   rst  : asynchronous reset, active LOW
//   bus  : pipe_ctrl_if.slave (hazard inputs in, enables/flushes/status out)
module pipe_ctrl (
   input  logic         clk,
   input  logic         rst,
   pipe_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

   state_t      state_q, state_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic if_id_flush, id_ex_flush, halted;
   logic load_use;

   assign load_use = bus.ex_read_mem & bus.ex_reg_w_en &
                     ((bus.id_rs_valid & (bus.id_rs == bus.ex_w_reg)) |
                      (bus.id_rt_valid & (bus.id_rt == bus.ex_w_reg)));

   always_comb begin
      state_d     = state_q;
      stall_cnt_d = stall_cnt_q;
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      halted      = 1'b0;

      case (state_q)
         HALT: begin
            // Frozen until reset; counter also frozen.
            halted = 1'b1;
         end
         default: begin
            // RUN and MEM_WAIT share one rule set: once memory is no longer
            // busy, the waiting cycle resolves exactly like a RUN cycle.
            if (bus.halt_req) begin
               state_d = HALT;
            end else if (bus.mem_busy) begin
               state_d = MEM_WAIT;
            end else begin
               state_d = RUN;
               if (bus.ex_branch_taken) begin
                  // Redirect: the fetched and decoded instructions are wrong-path,
                  // so any load-use on the decode instruction is moot.
                  {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
               end else if (load_use) begin
                  // Hold PC and IF/ID, push one bubble into ID/EX.
                  id_ex_en    = 1'b1;
                  id_ex_flush = 1'b1;
                  ex_mem_en   = 1'b1;
                  mem_wb_en   = 1'b1;
               end else begin
                  {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
               end
            end
            if (!pc_en && stall_cnt_q != 16'hFFFF)
               stall_cnt_d = stall_cnt_q + 16'd1;
         end
      endcase

      // Everything is quiet while reset is held, independent of the clock.
      if (!rst) begin
         {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
         if_id_flush = 1'b0;
         id_ex_flush = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= RUN;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.pc_en       = pc_en;
   assign bus.if_id_en    = if_id_en;
   assign bus.id_ex_en    = id_ex_en;
   assign bus.ex_mem_en   = ex_mem_en;
   assign bus.mem_wb_en   = mem_wb_en;
   assign bus.if_id_flush = if_id_flush;
   assign bus.id_ex_flush = id_ex_flush;
   assign bus.halted      = halted;
   assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pipe_ctrl_if bus();
   pipe_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));

   int unsigned errs = 0;
   int unsigned checks = 0;

   // Reference state: only "halted?" and the counter matter behaviourally.
   bit          m_halt = 1'b0;
   int unsigned m_cnt  = 0;

   logic [7:0] out_vec;
   assign out_vec = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en,
                     bus.mem_wb_en, bus.if_id_flush, bus.id_ex_flush, bus.halted};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected {pc,ifid,idex,exmem,memwb,ifid_fl,idex_fl,halted} from the rules.
   function automatic logic [7:0] exp_out();
      bit lu;
      lu = bus.ex_read_mem && bus.ex_reg_w_en &&
           ((bus.id_rs_valid && bus.id_rs == bus.ex_w_reg) ||
            (bus.id_rt_valid && bus.id_rt == bus.ex_w_reg));
      if (!rst)                    return 8'b0000_0000;
      if (m_halt)                  return 8'b0000_0001;
      if (bus.halt_req)            return 8'b0000_0000;
      if (bus.mem_busy)            return 8'b0000_0000;
      if (bus.ex_branch_taken)     return 8'b1111_1110;
      if (lu)                      return 8'b0011_1010;
      return 8'b1111_1000;
   endfunction

   task automatic set_idle();
      bus.id_rs = 3'd0; bus.id_rs_valid = 1'b0;
      bus.id_rt = 3'd0; bus.id_rt_valid = 1'b0;
      bus.ex_w_reg = 3'd0; bus.ex_reg_w_en = 1'b0; bus.ex_read_mem = 1'b0;
      bus.ex_branch_taken = 1'b0; bus.mem_busy = 1'b0; bus.halt_req = 1'b0;
   endtask

   task automatic set_load_use();
      bus.ex_read_mem = 1'b1; bus.ex_reg_w_en = 1'b1; bus.ex_w_reg = 3'd3;
      bus.id_rs = 3'd3; bus.id_rs_valid = 1'b1;
      bus.id_rt = 3'd5; bus.id_rt_valid = 1'b1;
   endtask

   // Called just after a falling edge with inputs already applied.
   task automatic cyc(input string tag);
      logic [7:0] e;
      if (!rst) begin m_halt = 1'b0; m_cnt = 0; end
      #1;
      e = exp_out();
      chk({tag, "/out"}, 32'(out_vec), 32'(e));
      chk({tag, "/cnt"}, 32'(bus.stall_cnt), m_cnt);
      @(posedge clk);
      if (rst && !m_halt) begin
         if (!e[7] && m_cnt < 32'hFFFF) m_cnt++;
         if (bus.halt_req) m_halt = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic rst_pulse(input string tag);
      rst = 1'b0;
      cyc(tag);
      rst = 1'b1;
   endtask

   initial begin
      set_idle();
      rst = 1'b0;
      @(negedge clk);
      cyc("rst0");
      cyc("rst1");
      chk("rst_cnt", 32'(bus.stall_cnt), 32'd0);
      rst = 1'b1;
      cyc("idle");

      // Load-use on rs -> one bubble, counter 0->1
      set_load_use();
      #1 chk("lu_out", 32'(out_vec), 32'h3A);
      cyc("lu");
      set_idle();
      chk("lu_cnt", 32'(bus.stall_cnt), 32'd1);
      cyc("lu_after");

      // Same but nothing actually read -> no stall
      set_load_use();
      bus.id_rs_valid = 1'b0; bus.id_rt_valid = 1'b0;
      cyc("lu_inv");
      set_idle();
      chk("lu_inv_cnt", 32'(bus.stall_cnt), 32'd1);

      // mem_busy 3 cycles with branch pending, then the flush cycle
      rst_pulse("rst_a");
      bus.ex_branch_taken = 1'b1;
      bus.mem_busy = 1'b1;
      repeat (3) cyc("mbusy");
      bus.mem_busy = 1'b0;
      chk("mbusy_cnt", 32'(bus.stall_cnt), 32'd3);
      #1 chk("br_after_wait", 32'(out_vec), 32'hFE);
      cyc("br_flush");
      chk("br_cnt", 32'(bus.stall_cnt), 32'd3);

      // Branch and load-use together: branch wins, counter unchanged
      set_load_use();
      bus.ex_branch_taken = 1'b1;
      cyc("br_lu");
      chk("br_lu_cnt", 32'(bus.stall_cnt), 32'd3);
      set_idle();

      // Halt concurrent with mem_busy -> permanent halt until reset
      bus.halt_req = 1'b1; bus.mem_busy = 1'b1;
      cyc("halt_req");
      set_idle();
      repeat (5) cyc("halted");
      chk("halted_flag", 32'(bus.halted), 32'd1);
      rst_pulse("rst_h");
      chk("halt_clr", 32'(bus.halted), 32'd0);
      chk("halt_cnt_clr", 32'(bus.stall_cnt), 32'd0);
      cyc("post_halt");

      // Randomized traffic, occasional halts and resets
      for (int i = 0; i < 3000; i++) begin
         bus.id_rs = 3'($urandom_range(7)); bus.id_rs_valid = 1'($urandom);
         bus.id_rt = 3'($urandom_range(7)); bus.id_rt_valid = 1'($urandom);
         bus.ex_w_reg = 3'($urandom_range(7));
         bus.ex_reg_w_en = ($urandom_range(3) != 0);
         bus.ex_read_mem = ($urandom_range(2) == 0);
         bus.ex_branch_taken = ($urandom_range(4) == 0);
         bus.mem_busy = ($urandom_range(4) == 0);
         bus.halt_req = ($urandom_range(150) == 0);
         if ((m_halt && $urandom_range(7) == 0) || $urandom_range(300) == 0)
            rst_pulse("rnd_rst");
         else
            cyc("rnd");
      end

      // Long memory stall saturates the counter
      set_idle();
      rst_pulse("rst_sat");
      bus.mem_busy = 1'b1;
      repeat (70000) cyc("sat");
      chk("sat_cnt", 32'(bus.stall_cnt), 32'hFFFF);
      bus.mem_busy = 1'b0;
      cyc("sat_release");
      chk("sat_hold", 32'(bus.stall_cnt), 32'hFFFF);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
